// File: rtl/ddr_cmd_pkg.sv
// Shared types and instruction layout for the AXI-Stream DDR4 command sequencer.
// Field offsets past the fixed opcode/ap/half_bl bits depend on the width parameters.
package ddr_cmd_pkg;

    typedef enum logic [3:0] {
        OP_NOP  = 4'd0,
        OP_PRE  = 4'd1,
        OP_ACT  = 4'd2,
        OP_RD   = 4'd3,
        OP_WR   = 4'd4,
        OP_REF  = 4'd5,
        OP_ZQ   = 4'd6,
        OP_PREA = 4'd7,
        OP_WAIT = 4'd8
    } opcode_e;

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_ISSUE,
        ST_WAIT
    } state_e;

    localparam int OPCODE_LSB  = 0;
    localparam int AP_BIT      = 4;
    localparam int HALF_BL_BIT = 5;
    localparam int BANK_LSB    = 6;

    function automatic int bg_lsb(input int bank_w);
        return BANK_LSB + bank_w;
    endfunction

    function automatic int addr_lsb(input int bank_w, input int bg_w);
        return BANK_LSB + bank_w + bg_w;
    endfunction

endpackage

// File: rtl/ddr_cmd_slot_dec.sv
// Combinational decode of one packed 32-bit instruction into command strobes,
// address fields, WAIT count and illegal-opcode flag.
module ddr_cmd_slot_dec
    import ddr_cmd_pkg::*;
#(
    parameter int BG_WIDTH   = 2,
    parameter int BANK_WIDTH = 2,
    parameter int COL_WIDTH  = 10,
    parameter int ROW_WIDTH  = 17,
    parameter int WAIT_WIDTH = 16
) (
    input  logic [31:0]           instr,
    output logic                  wr,
    output logic                  rd,
    output logic                  pre,
    output logic                  act,
    output logic                  refresh,
    output logic                  zq,
    output logic                  nop,
    output logic                  ap,
    output logic                  half_bl,
    output logic                  pall,
    output logic                  is_wait,
    output logic                  illegal,
    output logic [BG_WIDTH-1:0]   bg,
    output logic [BANK_WIDTH-1:0] bank,
    output logic [COL_WIDTH-1:0]  col,
    output logic [ROW_WIDTH-1:0]  row,
    output logic [WAIT_WIDTH-1:0] wait_n
);

    localparam int BG_LSB   = bg_lsb(BANK_WIDTH);
    localparam int ADDR_LSB = addr_lsb(BANK_WIDTH, BG_WIDTH);

    // Upper instruction bits beyond the address field are reserved.
    logic unused_bits;
    assign unused_bits = ^instr;

    assign bank   = instr[BANK_LSB +: BANK_WIDTH];
    assign bg     = instr[BG_LSB +: BG_WIDTH];
    assign row    = instr[ADDR_LSB +: ROW_WIDTH];
    assign col    = instr[ADDR_LSB +: COL_WIDTH];
    assign wait_n = instr[ADDR_LSB +: WAIT_WIDTH];

    always_comb begin
        wr      = 1'b0;
        rd      = 1'b0;
        pre     = 1'b0;
        act     = 1'b0;
        refresh = 1'b0;
        zq      = 1'b0;
        nop     = 1'b0;
        ap      = 1'b0;
        half_bl = 1'b0;
        pall    = 1'b0;
        is_wait = 1'b0;
        illegal = 1'b0;
        case (instr[OPCODE_LSB +: 4])
            OP_NOP:  nop = 1'b1;
            OP_PRE:  pre = 1'b1;
            OP_ACT:  act = 1'b1;
            OP_RD: begin
                rd      = 1'b1;
                ap      = instr[AP_BIT];
                half_bl = instr[HALF_BL_BIT];
            end
            OP_WR: begin
                wr      = 1'b1;
                ap      = instr[AP_BIT];
                half_bl = instr[HALF_BL_BIT];
            end
            OP_REF:  refresh = 1'b1;
            OP_ZQ:   zq = 1'b1;
            OP_PREA: begin
                pre  = 1'b1;
                pall = 1'b1;
            end
            OP_WAIT: begin
                nop     = 1'b1;
                is_wait = 1'b1;
            end
            default: begin
                nop     = 1'b1;
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/axis_ddr_cmd_seq.sv
// Accepts beats of packed DDR4 instructions on AXI-Stream and issues them one
// slot group per enabled cycle, with WAIT idle insertion, pause and status.
module axis_ddr_cmd_seq
    import ddr_cmd_pkg::*;
#(
    parameter int BG_WIDTH   = 2,
    parameter int BANK_WIDTH = 2,
    parameter int COL_WIDTH  = 10,
    parameter int ROW_WIDTH  = 17,
    parameter int AXIS_WIDTH = 512,
    parameter int SLOTS      = 4,
    parameter int WAIT_WIDTH = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [AXIS_WIDTH-1:0]       s_axis_tdata,
    input  logic                        s_axis_tvalid,
    input  logic                        s_axis_tlast,
    output logic                        s_axis_tready,
    input  logic                        issue_en,
    output logic [SLOTS-1:0]            ddr_write,
    output logic [SLOTS-1:0]            ddr_read,
    output logic [SLOTS-1:0]            ddr_pre,
    output logic [SLOTS-1:0]            ddr_act,
    output logic [SLOTS-1:0]            ddr_ref,
    output logic [SLOTS-1:0]            ddr_zq,
    output logic [SLOTS-1:0]            ddr_nop,
    output logic [SLOTS-1:0]            ddr_ap,
    output logic [SLOTS-1:0]            ddr_half_bl,
    output logic [SLOTS-1:0]            ddr_pall,
    output logic [SLOTS*BG_WIDTH-1:0]   ddr_bg,
    output logic [SLOTS*BANK_WIDTH-1:0] ddr_bank,
    output logic [SLOTS*COL_WIDTH-1:0]  ddr_col,
    output logic [SLOTS*ROW_WIDTH-1:0]  ddr_row,
    output logic                        busy,
    output logic                        seq_done,
    output logic                        err_illegal,
    output logic [31:0]                 cmd_count,
    output logic [3:0]                  latest_instr_id
);

    localparam int G  = AXIS_WIDTH / (32 * SLOTS);
    localparam int GW = (G > 1) ? $clog2(G) : 1;
    localparam logic [GW-1:0] G_LAST = GW'(G - 1);

    if (addr_lsb(BANK_WIDTH, BG_WIDTH) + ROW_WIDTH > 32) begin : g_chk_fields
        $error("instruction fields exceed 32 bits");
    end
    if (AXIS_WIDTH % (32 * SLOTS) != 0 || WAIT_WIDTH > ROW_WIDTH) begin : g_chk_widths
        $error("illegal AXIS_WIDTH / WAIT_WIDTH parameterisation");
    end

    state_e                  state_q, state_d;
    logic [AXIS_WIDTH-1:0]   beat_q;
    logic                    last_q;
    logic [GW-1:0]           g_q;
    logic [WAIT_WIDTH-1:0]   wait_q;
    logic                    wait_last_q;
    logic                    alive_q;
    logic                    done_pend_q;

    logic [31:0]             slot_instr [SLOTS];
    logic [SLOTS-1:0]        d_wr, d_rd, d_pre, d_act, d_ref, d_zq, d_nop, d_ap, d_hbl, d_pall;
    logic [SLOTS-1:0]        d_wait, d_illegal;
    logic [SLOTS*BG_WIDTH-1:0]   d_bg;
    logic [SLOTS*BANK_WIDTH-1:0] d_bank;
    logic [SLOTS*COL_WIDTH-1:0]  d_col;
    logic [SLOTS*ROW_WIDTH-1:0]  d_row;
    logic [WAIT_WIDTH-1:0]   d_wait_n [SLOTS];

    logic [WAIT_WIDTH-1:0]   grp_wait_n;
    logic                    grp_wait;
    logic [31:0]             grp_cmds;
    logic                    issue, last_grp, accept, wait_tick, wait_end;

    for (genvar i = 0; i < SLOTS; i++) begin : g_slot
        assign slot_instr[i] = beat_q[(int'(g_q) * SLOTS + i) * 32 +: 32];
        ddr_cmd_slot_dec #(
            .BG_WIDTH  (BG_WIDTH),
            .BANK_WIDTH(BANK_WIDTH),
            .COL_WIDTH (COL_WIDTH),
            .ROW_WIDTH (ROW_WIDTH),
            .WAIT_WIDTH(WAIT_WIDTH)
        ) u_dec (
            .instr  (slot_instr[i]),
            .wr     (d_wr[i]),
            .rd     (d_rd[i]),
            .pre    (d_pre[i]),
            .act    (d_act[i]),
            .refresh(d_ref[i]),
            .zq     (d_zq[i]),
            .nop    (d_nop[i]),
            .ap     (d_ap[i]),
            .half_bl(d_hbl[i]),
            .pall   (d_pall[i]),
            .is_wait(d_wait[i]),
            .illegal(d_illegal[i]),
            .bg     (d_bg[i*BG_WIDTH +: BG_WIDTH]),
            .bank   (d_bank[i*BANK_WIDTH +: BANK_WIDTH]),
            .col    (d_col[i*COL_WIDTH +: COL_WIDTH]),
            .row    (d_row[i*ROW_WIDTH +: ROW_WIDTH]),
            .wait_n (d_wait_n[i])
        );
    end

    // The highest-index WAIT in the group wins; NOP, WAIT and illegal slots are not counted.
    always_comb begin
        grp_wait_n = '0;
        grp_cmds   = '0;
        for (int i = 0; i < SLOTS; i++) begin
            if (d_wait[i]) grp_wait_n = d_wait_n[i];
            grp_cmds = grp_cmds + {31'd0, ~d_nop[i]};
        end
        grp_wait = (grp_wait_n != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_EMPTY;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (accept) state_d = ST_ISSUE;
            ST_ISSUE: begin
                if (issue) begin
                    if (grp_wait)                 state_d = ST_WAIT;
                    else if (last_grp && !accept) state_d = ST_EMPTY;
                end
            end
            ST_WAIT:  if (wait_end) state_d = wait_last_q ? ST_EMPTY : ST_ISSUE;
            default:  state_d = ST_EMPTY;
        endcase
    end

    // Ready on the last group lets the next beat load in the same edge, so beats stream without a bubble.
    always_comb begin
        issue         = (state_q == ST_ISSUE) && issue_en;
        last_grp      = (g_q == G_LAST);
        wait_tick     = (state_q == ST_WAIT) && issue_en;
        wait_end      = wait_tick && (wait_q == WAIT_WIDTH'(1));
        s_axis_tready = alive_q && ((state_q == ST_EMPTY) || (issue && last_grp && !grp_wait));
        accept        = s_axis_tvalid && s_axis_tready;
        busy          = (state_q != ST_EMPTY);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_q      <= '0;
            last_q      <= 1'b0;
            g_q         <= '0;
            wait_q      <= '0;
            wait_last_q <= 1'b0;
            alive_q     <= 1'b0;
            done_pend_q <= 1'b0;
            seq_done    <= 1'b0;
        end else begin
            alive_q <= 1'b1;
            if (accept) begin
                beat_q <= s_axis_tdata;
                last_q <= s_axis_tlast;
                g_q    <= '0;
            end else if (issue && !last_grp) begin
                g_q <= g_q + GW'(1);
            end
            if (issue && grp_wait) begin
                wait_q      <= grp_wait_n;
                wait_last_q <= last_grp;
            end else if (wait_tick) begin
                wait_q <= wait_q - WAIT_WIDTH'(1);
            end
            done_pend_q <= last_q && ((issue && last_grp && !grp_wait) || (wait_end && wait_last_q));
            seq_done    <= done_pend_q;
        end
    end

    // Registered command bus: the decoded group when issuing, otherwise the idle pattern.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {ddr_write, ddr_read, ddr_pre, ddr_act, ddr_ref} <= '0;
            {ddr_zq, ddr_nop, ddr_ap, ddr_half_bl, ddr_pall} <= '0;
            {ddr_bg, ddr_bank, ddr_col, ddr_row}             <= '0;
            err_illegal     <= 1'b0;
            cmd_count       <= '0;
            latest_instr_id <= '0;
        end else if (issue) begin
            {ddr_write, ddr_read, ddr_pre, ddr_act, ddr_ref} <= {d_wr, d_rd, d_pre, d_act, d_ref};
            {ddr_zq, ddr_nop, ddr_ap, ddr_half_bl, ddr_pall} <= {d_zq, d_nop, d_ap, d_hbl, d_pall};
            {ddr_bg, ddr_bank, ddr_col, ddr_row}             <= {d_bg, d_bank, d_col, d_row};
            cmd_count       <= cmd_count + grp_cmds;
            latest_instr_id <= slot_instr[0][3:0];
            if (|d_illegal) err_illegal <= 1'b1;
        end else begin
            {ddr_write, ddr_read, ddr_pre, ddr_act, ddr_ref} <= '0;
            {ddr_zq, ddr_ap, ddr_half_bl, ddr_pall}          <= '0;
            ddr_nop                                          <= '1;
            {ddr_bg, ddr_bank, ddr_col, ddr_row}             <= '0;
        end
    end

endmodule

// File: tb/tb_axis_ddr_cmd_seq.sv
// Self-checking bench for axis_ddr_cmd_seq: directed steps plus random beats,
// compared cycle by cycle against a token-queue model of the issue schedule.
module tb_axis_ddr_cmd_seq;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic [511:0] s_axis_tdata = '0;
    logic         s_axis_tvalid = 1'b0;
    logic         s_axis_tlast = 1'b0;
    logic         s_axis_tready;
    logic         issue_en = 1'b1;
    logic [3:0]   ddr_write, ddr_read, ddr_pre, ddr_act, ddr_ref, ddr_zq;
    logic [3:0]   ddr_nop, ddr_ap, ddr_half_bl, ddr_pall;
    logic [7:0]   ddr_bg, ddr_bank;
    logic [39:0]  ddr_col;
    logic [67:0]  ddr_row;
    logic         busy, seq_done, err_illegal;
    logic [31:0]  cmd_count;
    logic [3:0]   latest_instr_id;

    always #5 clk = ~clk;

    axis_ddr_cmd_seq dut (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
        .issue_en(issue_en),
        .ddr_write(ddr_write), .ddr_read(ddr_read), .ddr_pre(ddr_pre), .ddr_act(ddr_act),
        .ddr_ref(ddr_ref), .ddr_zq(ddr_zq), .ddr_nop(ddr_nop), .ddr_ap(ddr_ap),
        .ddr_half_bl(ddr_half_bl), .ddr_pall(ddr_pall),
        .ddr_bg(ddr_bg), .ddr_bank(ddr_bank), .ddr_col(ddr_col), .ddr_row(ddr_row),
        .busy(busy), .seq_done(seq_done), .err_illegal(err_illegal),
        .cmd_count(cmd_count), .latest_instr_id(latest_instr_id)
    );

    typedef struct {
        logic [39:0]  strobe;
        logic [123:0] field;
        int           cmds;
        bit           illegal;
        logic [3:0]   op0;
        int           wait_n;
    } grp_t;

    typedef struct {
        bit   idle;
        grp_t g;
        bit   done;
    } tok_t;

    typedef struct {
        logic [511:0] data;
        logic         last;
    } beat_t;

    localparam logic [39:0] IDLE_STROBE = {24'h0, 4'hF, 12'h0};

    tok_t         toks[$];
    beat_t        tx_q[$];
    int           checks = 0;
    int           errors = 0;
    int           seen_done = 0;
    bit           alive = 0;
    bit           done_prev = 0;
    logic [39:0]  exp_strobe = '0;
    logic [123:0] exp_field = '0;
    logic [31:0]  exp_cmd = '0;
    logic         exp_err = 0, exp_seq_done = 0, exp_busy = 0;
    logic [3:0]   exp_op0 = '0;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [3:0] op, input bit ap, input bit hb,
                                       input logic [1:0] bank, input logic [1:0] bg,
                                       input logic [21:0] addr);
        return {addr, bg, bank, hb, ap, op};
    endfunction

    // Expected group output straight from the instruction layout and opcode table.
    function automatic grp_t make_group(input logic [127:0] w);
        grp_t r;
        logic [3:0] wr, rd, pre, act, rf, zq, nop, ap, hb, pall;
        logic [7:0] bgv, bkv;
        logic [39:0] colv;
        logic [67:0] rowv;
        logic [31:0] ins;
        {wr, rd, pre, act, rf, zq, nop, ap, hb, pall} = '0;
        bgv = '0; bkv = '0; colv = '0; rowv = '0;
        r.cmds = 0; r.illegal = 0; r.wait_n = 0;
        for (int s = 0; s < 4; s++) begin
            ins = w[s*32 +: 32];
            bkv[s*2 +: 2]   = ins[7:6];
            bgv[s*2 +: 2]   = ins[9:8];
            colv[s*10 +: 10] = ins[19:10];
            rowv[s*17 +: 17] = ins[26:10];
            case (ins[3:0])
                4'd0: nop[s] = 1;
                4'd1: pre[s] = 1;
                4'd2: act[s] = 1;
                4'd3: begin rd[s] = 1; ap[s] = ins[4]; hb[s] = ins[5]; end
                4'd4: begin wr[s] = 1; ap[s] = ins[4]; hb[s] = ins[5]; end
                4'd5: rf[s] = 1;
                4'd6: zq[s] = 1;
                4'd7: begin pre[s] = 1; pall[s] = 1; end
                4'd8: begin nop[s] = 1; r.wait_n = int'(ins[25:10]); end
                default: begin nop[s] = 1; r.illegal = 1; end
            endcase
            if (!nop[s]) r.cmds++;
        end
        r.strobe = {wr, rd, pre, act, rf, zq, nop, ap, hb, pall};
        r.field  = {bgv, bkv, colv, rowv};
        r.op0    = w[3:0];
        return r;
    endfunction

    // A beat becomes one token per group followed by one idle token per WAIT cycle.
    task automatic push_beat(input logic [511:0] d, input logic last);
        tok_t t;
        for (int gi = 0; gi < 4; gi++) begin
            t.g    = make_group(d[gi*128 +: 128]);
            t.idle = 0;
            t.done = last && gi == 3 && t.g.wait_n == 0;
            toks.push_back(t);
            for (int k = 0; k < t.g.wait_n; k++) begin
                t.idle = 1;
                t.done = last && gi == 3 && k == t.g.wait_n - 1;
                toks.push_back(t);
            end
        end
    endtask

    function automatic bit exp_tready();
        return alive && (toks.size() == 0 || (issue_en && toks.size() == 1 && !toks[0].idle));
    endfunction

    task automatic model_edge(input bit acc, input logic [511:0] d, input logic last);
        tok_t t;
        exp_seq_done = done_prev;
        done_prev    = 0;
        exp_strobe   = IDLE_STROBE;
        exp_field    = '0;
        alive        = 1;
        if (issue_en && toks.size() > 0) begin
            t = toks.pop_front();
            done_prev = t.done;
            if (!t.idle) begin
                exp_strobe = t.g.strobe;
                exp_field  = t.g.field;
                exp_cmd    = exp_cmd + 32'(t.g.cmds);
                exp_err    = exp_err | t.g.illegal;
                exp_op0    = t.g.op0;
            end
        end
        if (acc) push_beat(d, last);
        exp_busy = toks.size() > 0;
    endtask

    task automatic model_reset();
        toks.delete();
        tx_q.delete();
        alive = 0; done_prev = 0;
        exp_strobe = '0; exp_field = '0; exp_cmd = '0;
        exp_err = 0; exp_seq_done = 0; exp_busy = 0; exp_op0 = '0;
    endtask

    task automatic check_outputs();
        chk("strobes", {ddr_write, ddr_read, ddr_pre, ddr_act, ddr_ref, ddr_zq,
                        ddr_nop, ddr_ap, ddr_half_bl, ddr_pall}, exp_strobe);
        chk("fields", {ddr_bg, ddr_bank, ddr_col, ddr_row}, exp_field);
        chk("cmd_count", cmd_count, exp_cmd);
        chk("status", {busy, seq_done, err_illegal, latest_instr_id},
            {exp_busy, exp_seq_done, exp_err, exp_op0});
    endtask

    task automatic tick();
        bit acc, rdy;
        if (tx_q.size() > 0) begin
            s_axis_tvalid = 1;
            s_axis_tdata  = tx_q[0].data;
            s_axis_tlast  = tx_q[0].last;
        end else begin
            s_axis_tvalid = 0;
            s_axis_tlast  = 0;
        end
        @(negedge clk);
        rdy = exp_tready();
        chk("tready", s_axis_tready, rdy);
        acc = rdy && s_axis_tvalid;
        @(posedge clk);
        model_edge(acc, s_axis_tdata, s_axis_tlast);
        if (acc) void'(tx_q.pop_front());
        #1;
        check_outputs();
        seen_done += int'(seq_done);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 0;
        model_reset();
        #1 chk("reset_async", {ddr_write, ddr_read, ddr_pre, ddr_act, ddr_ref, ddr_zq, ddr_nop,
                               ddr_ap, ddr_half_bl, ddr_pall, ddr_bg, ddr_bank, ddr_col, ddr_row,
                               busy, seq_done, err_illegal, latest_instr_id, cmd_count,
                               s_axis_tready}, '0);
        @(posedge clk);
        #1 chk("reset_held", {ddr_nop, busy, err_illegal, cmd_count, s_axis_tready}, '0);
        rst_n = 1;
    endtask

    task automatic drain(input int max);
        int n = 0;
        while ((tx_q.size() > 0 || toks.size() > 0) && n < max) begin
            tick();
            n++;
        end
        chk("drain_bound", (n < max) ? 1 : 0, 1);
        tick();
        tick();
    endtask

    function automatic logic [31:0] rand_legal();
        return mk(4'($urandom_range(1, 7)), 1'($urandom), 1'($urandom), 2'($urandom),
                  2'($urandom), 22'($urandom));
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] ins;
        int k;
        ins = $urandom;
        k = $urandom_range(0, 15);
        if (k < 10)       ins[3:0] = 4'($urandom_range(0, 7));
        else if (k < 13)  ins[3:0] = 4'd8;
        else if (k == 13) ins[3:0] = 4'($urandom_range(9, 15));
        else              ins[3:0] = 4'($urandom_range(3, 4));
        if (ins[3:0] == 4'd8) ins[25:10] = 16'($urandom_range(0, 3));
        return ins;
    endfunction

    initial begin
        beat_t b;

        // Reset release with no traffic: idle pattern and ready.
        do_reset();
        repeat (3) tick();

        // ACT/RD(ap)/WR/PRE pattern across all four groups.
        b.last = 0;
        for (int k = 0; k < 16; k++) begin
            case (k % 4)
                0: b.data[k*32 +: 32] = mk(4'd2, 0, 0, 2'd2, 2'd1, 22'h1ABCD);
                1: b.data[k*32 +: 32] = mk(4'd3, 1, 0, 2'd2, 2'd1, 22'h1ABCD);
                2: b.data[k*32 +: 32] = mk(4'd4, 0, 0, 2'd2, 2'd1, 22'h1ABCD);
                default: b.data[k*32 +: 32] = mk(4'd1, 0, 0, 2'd2, 2'd1, 22'h1ABCD);
            endcase
        end
        tx_q.push_back(b);
        drain(100);
        chk("cmd_count_16", cmd_count, 32'd16);

        // Two back-to-back beats streaming without a gap.
        for (int n = 0; n < 2; n++) begin
            for (int k = 0; k < 16; k++) b.data[k*32 +: 32] = rand_legal();
            tx_q.push_back(b);
        end
        drain(100);

        // WAIT N=5 in group 1 slot 2.
        for (int k = 0; k < 16; k++) b.data[k*32 +: 32] = rand_legal();
        b.data[6*32 +: 32] = mk(4'd8, 0, 0, 2'd0, 2'd0, 22'd5);
        tx_q.push_back(b);
        drain(100);

        // Pause for 3 cycles mid-beat.
        for (int k = 0; k < 16; k++) b.data[k*32 +: 32] = rand_legal();
        tx_q.push_back(b);
        repeat (3) tick();
        issue_en = 0;
        repeat (3) tick();
        issue_en = 1;
        drain(100);

        // Reset asserted mid-WAIT discards the rest of the beat.
        for (int k = 0; k < 16; k++) b.data[k*32 +: 32] = rand_legal();
        b.data[3*32 +: 32] = mk(4'd8, 0, 0, 2'd0, 2'd0, 22'd6);
        tx_q.push_back(b);
        repeat (4) tick();
        do_reset();
        repeat (5) tick();

        // Illegal opcode in a TLAST beat.
        seen_done = 0;
        for (int k = 0; k < 16; k++) b.data[k*32 +: 32] = rand_legal();
        b.data[5*32 +: 32] = mk(4'd12, 1, 1, 2'd3, 2'd3, 22'h3FFFFF);
        b.last = 1;
        tx_q.push_back(b);
        drain(100);
        chk("err_sticky", err_illegal, 1'b1);
        chk("seq_done_once", seen_done, 1);

        // Random program with random pauses.
        for (int n = 0; n < 30; n++) begin
            for (int k = 0; k < 16; k++) b.data[k*32 +: 32] = rand_instr();
            b.last = ($urandom_range(0, 3) == 0);
            tx_q.push_back(b);
        end
        for (int n = 0; n < 3000 && (tx_q.size() > 0 || toks.size() > 0); n++) begin
            issue_en = ($urandom_range(0, 4) != 0);
            tick();
        end
        issue_en = 1;
        drain(500);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axis_ddr_cmd_seq.md
# axis_ddr_cmd_seq

Parametrised successor of the AXI-Stream instruction decoder. It takes packed 32-bit DDR4 instructions on an AXI4-Stream slave and issues them, SLOTS commands per fabric cycle, onto the per-slot command bus of the DDR4 adapter. Compared with the previous decoder it adds:
- configurable beat width, slot count and field widths;
- a full opcode set (refresh, ZQ, precharge-all, auto-precharge, half-BL);
- a WAIT opcode that inserts idle cycles;
- bubble-free beat-to-beat streaming;
- pause control, TLAST completion signalling and error status.

## Interface
- BG_WIDTH, 2, bank-group field width
- BANK_WIDTH, 2, bank field width
- COL_WIDTH, 10, column field width
- ROW_WIDTH, 17, row field width
- AXIS_WIDTH, 512, stream data width; multiple of 32·SLOTS
- SLOTS, 4, commands per cycle (one slot group)
- WAIT_WIDTH, 16, WAIT count width; ≤ ROW_WIDTH
- clk  in  1  single clock
- rst_n  in  1  reset, asynchronous, active-low
- s_axis_tdata  in  AXIS_WIDTH  instruction beat, instruction k at [32k+:32]
- s_axis_tvalid / s_axis_tlast  in  1  stream valid / end of program
- s_axis_tready  out  1  beat accepted when tvalid&tready at clk edge
- issue_en  in  1  0 = pause: idle output, state held
- ddr_write, ddr_read, ddr_pre, ddr_act, ddr_ref, ddr_zq, ddr_nop, ddr_ap, ddr_half_bl, ddr_pall  out  SLOTS  per-slot strobes, bit i = slot i
- ddr_bg / ddr_bank / ddr_col / ddr_row  out  SLOTS·width  per-slot fields
- busy  out  1  beat buffered or WAIT pending
- seq_done  out  1  one-cycle pulse, see Operation
- err_illegal  out  1  sticky, illegal opcode seen
- cmd_count  out  32  wrapping count of issued non-NOP commands
- latest_instr_id  out  4  opcode of slot 0 of the last issued group

## Operation
- Instruction: [3:0] opcode, [4] ap, [5] half_bl, then bank, bg, then addr field. row = addr[ROW_WIDTH-1:0], col = addr[COL_WIDTH-1:0]. Elaboration check: 6+BANK+BG+ROW ≤ 32.
- Opcodes:
  - 0 NOP
  - 1 PRE
  - 2 ACT
  - 3 RD: ddr_read, plus ap and half_bl from the instruction
  - 4 WR: ddr_write, plus ap and half_bl from the instruction
  - 5 REF
  - 6 ZQ
  - 7 PREA: ddr_pre and ddr_pall
  - 8 WAIT
  - 9–15 illegal: slot issues NOP and err_illegal is set
- Fields are driven for every slot of an issued group regardless of opcode. ap and half_bl are forced to 0 for opcodes other than RD and WR.
- A beat holds G = AXIS_WIDTH/(32·SLOTS) groups. Groups are issued in order 0..G-1, one per enabled cycle.
- FSM states:
  - EMPTY: no beat held.
  - ISSUE: beat held, group index g.
  - WAIT: all-NOP cycles, counter counting down.
- WAIT opcode, count N = addr[WAIT_WIDTH-1:0]. The WAIT slot itself issues as NOP. The rest of its group issues normally. Then exactly N all-NOP cycles follow before the next group. N=0 inserts nothing. Multiple WAITs in one group: only the highest-index WAIT's N is used.
- Idle output (EMPTY, WAIT, or issue_en=0): ddr_nop all ones, every other output bus zero.
- s_axis_tready = EMPTY, or (ISSUE, g=G-1, issue_en=1, and the last group contains no WAIT with N>0). This allows a new beat every G cycles with no bubble.
- seq_done pulses in the cycle after the final group of a TLAST beat has issued and any WAIT from that group has completed.
- cmd_count adds the number of non-NOP, non-WAIT, legal slots per issued group.

## Timing
- Reset (asynchronous, rst_n low): every output is 0, including ddr_nop, s_axis_tready, busy, cmd_count and err_illegal. Buffer and counters are cleared and state is EMPTY. Reset mid-beat or mid-WAIT discards all pending work.
- First edge after reset release: outputs take the idle pattern and s_axis_tready=1.
- Latency: a beat accepted at edge T puts group 0 on the registered outputs after edge T+1.
- issue_en=0 in ISSUE or WAIT: g and the WAIT counter freeze and the output is idle. Beat acceptance in EMPTY is still allowed while paused.
- tvalid held low while EMPTY: idle output every cycle, no error.
- cmd_count wraps at 2^32 without saturation.

## Structure
- Package ddr_cmd_pkg holds:
  - the opcode enum (4 bits);
  - instruction field offset localparams, derived from the width parameters;
  - the state enum.
- Sub-module ddr_cmd_slot_dec: combinational decode of one 32-bit instruction to its strobes, fields, wait count and illegal flag. It is instantiated SLOTS times.
- The top level holds the beat buffer, the group counter, the WAIT counter, the FSM and the status registers.

## Test plan
- Reset release, tvalid=0 → ddr_nop=4'b1111 and all other buses 0 from cycle 1; s_axis_tready=1.
- One beat, 16 instructions ACT, RD(ap=1), WR, PRE, with row 0x1ABCD, bank 2, bg 1 → 4 consecutive groups appear starting at T+1 with correct strobes and fields. ddr_ap is set only on the RD slot. cmd_count=16.
- Two back-to-back beats, tvalid held high → tready pulses every 4th cycle and 8 consecutive non-idle groups are issued with no gap.
- WAIT N=5 in group 1 slot 2 → group 1's other slots issue, then exactly 5 idle cycles, then group 2.
- issue_en low for 3 cycles mid-beat, and rst_n asserted mid-WAIT → the pause delays issue by exactly 3 cycles with no group lost. Reset gives zero outputs immediately, then idle, and nothing stale is issued.
- Opcode 12 plus TLAST beat → that slot issues NOP, err_illegal stays 1, and seq_done pulses once after the last group.
